// File: rtl/enigma_pkg.sv
// Shared constants, types and helpers for the enigma arbiter and its ID scoreboard.
package enigma_pkg;

    localparam int PW  = 128;
    localparam int IDW = 5;
    localparam int QW  = 2;
    localparam int SBW = 1 << (IDW + 1);

    typedef logic [IDW:0]  enigma_id_t;
    typedef logic [QW-1:0] enigma_qos_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } enigma_port_e;

    // The port number sits in the MSB so both ports share one flat ID space.
    function automatic enigma_id_t make_id(enigma_port_e port, logic [IDW-1:0] id);
        return {port, id};
    endfunction

endpackage

// File: rtl/enigma_id_sb.sv
// Outstanding-ID scoreboard: one bit per {port,id}, one set port, one clear port and two lookups.
module enigma_id_sb
    import enigma_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [IDW:0]     set_id,
    input  logic             clr_en,
    input  logic [IDW:0]     clr_id,
    input  logic [IDW:0]     lookup_a_id,
    input  logic [IDW:0]     lookup_b_id,
    output logic             lookup_a_hit,
    output logic             lookup_b_hit
);

    logic [SBW-1:0] sb;
    logic [SBW-1:0] set_mask;
    logic [SBW-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) begin
            set_mask[set_id] = 1'b1;
        end
        if (clr_en) begin
            clr_mask[clr_id] = 1'b1;
        end
    end

    // Set is OR-ed in after the clear so a same-bit collision leaves the bit set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            sb <= (sb & ~clr_mask) | set_mask;
        end
    end

    assign lookup_a_hit = sb[lookup_a_id];
    assign lookup_b_hit = sb[lookup_b_id];

endmodule

// File: rtl/enigma_arbiter.sv
// QoS-aware two-port arbiter merging ports a and b onto channel c with a one-entry output stage.
// Optional aging of losing requesters is enabled with `define ENIGMA_ARB_AGING_EN.
module enigma_arbiter
    import enigma_pkg::*;
`ifdef ENIGMA_ARB_AGING_EN
#(
    parameter int AGE_MAX = 15
)
`endif
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PW-1:0]    payload_a,
    input  logic [IDW-1:0]   id_a,
    input  logic [QW-1:0]    qos_a,
    input  logic             valid_a,
    output logic             ready_a,
    input  logic [PW-1:0]    payload_b,
    input  logic [IDW-1:0]   id_b,
    input  logic [QW-1:0]    qos_b,
    input  logic             valid_b,
    output logic             ready_b,
    output logic             valid_c,
    output logic [PW-1:0]    payload_c,
    output logic [IDW:0]     id_c,
    output logic [QW-1:0]    qos_c,
    input  logic             ready_c,
    input  logic             conflict_c,
    input  logic             release_c,
    input  logic [IDW:0]     releaseid_c
);

    logic        hit_a;
    logic        hit_b;
    logic        elig_a;
    logic        elig_b;
    logic        xfer;
    logic        free;
    logic        b_pref;
    logic        win_a;
    logic        win_b;
    logic        grant_a;
    logic        grant_b;
    logic        accept;
    logic        rr;
    enigma_id_t  full_id_a;
    enigma_id_t  full_id_b;
    enigma_id_t  win_id;
    enigma_qos_t eff_qos_a;
    enigma_qos_t eff_qos_b;

    assign full_id_a = make_id(PORT_A, id_a);
    assign full_id_b = make_id(PORT_B, id_b);

    enigma_id_sb u_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_en       (accept),
        .set_id       (win_id),
        .clr_en       (release_c),
        .clr_id       (releaseid_c),
        .lookup_a_id  (full_id_a),
        .lookup_b_id  (full_id_b),
        .lookup_a_hit (hit_a),
        .lookup_b_hit (hit_b)
    );

    assign xfer   = valid_c & ready_c & ~conflict_c;
    assign free   = ~valid_c | xfer;
    assign elig_a = valid_a & ~hit_a;
    assign elig_b = valid_b & ~hit_b;

`ifdef ENIGMA_ARB_AGING_EN
    localparam logic [3:0] AGE_LIM = 4'(AGE_MAX);

    logic [3:0] age_a;
    logic [3:0] age_b;
    logic       arb;

    assign arb = free & (elig_a | elig_b);

    // A port only ages on cycles where it was eligible, arbitration ran, and it lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            age_a <= '0;
            age_b <= '0;
        end else begin
            if (grant_a) begin
                age_a <= '0;
            end else if (arb && elig_a && age_a != AGE_LIM) begin
                age_a <= age_a + 4'd1;
            end
            if (grant_b) begin
                age_b <= '0;
            end else if (arb && elig_b && age_b != AGE_LIM) begin
                age_b <= age_b + 4'd1;
            end
        end
    end

    assign eff_qos_a = (age_a == AGE_LIM) ? '1 : qos_a;
    assign eff_qos_b = (age_b == AGE_LIM) ? '1 : qos_b;
`else
    assign eff_qos_a = qos_a;
    assign eff_qos_b = qos_b;
`endif

    assign b_pref = (eff_qos_b > eff_qos_a) | ((eff_qos_b == eff_qos_a) & rr);

    always_comb begin
        win_a = 1'b0;
        win_b = 1'b0;
        if (elig_a && elig_b) begin
            win_a = ~b_pref;
            win_b = b_pref;
        end else begin
            win_a = elig_a;
            win_b = elig_b;
        end
    end

    // Gating with rst_n keeps both ports stalled during the reset cycle.
    assign ready_a = rst_n & free & win_a;
    assign ready_b = rst_n & free & win_b;
    assign grant_a = ready_a & valid_a;
    assign grant_b = ready_b & valid_b;
    assign accept  = grant_a | grant_b;
    assign win_id  = grant_b ? full_id_b : full_id_a;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr <= 1'b0;
        end else if (grant_a) begin
            rr <= 1'b1;
        end else if (grant_b) begin
            rr <= 1'b0;
        end
    end

    // Output stage holds its beat on conflict or stall and only reloads when free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_c   <= 1'b0;
            payload_c <= '0;
            id_c      <= '0;
            qos_c     <= '0;
        end else if (accept) begin
            valid_c   <= 1'b1;
            payload_c <= grant_b ? payload_b : payload_a;
            id_c      <= win_id;
            qos_c     <= grant_b ? qos_b : qos_a;
        end else if (free) begin
            valid_c   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_enigma_arbiter.sv
// Scoreboard-driven bench for enigma_arbiter; expected beats are queued at accept and popped on transfer.
module tb_enigma_arbiter;
    import enigma_pkg::*;

    typedef struct {
        logic [PW-1:0]  p;
        logic [IDW:0]   id;
        logic [QW-1:0]  q;
    } beat_t;

    logic           clk;
    logic           rst_n;
    logic [PW-1:0]  payload_a;
    logic [IDW-1:0] id_a;
    logic [QW-1:0]  qos_a;
    logic           valid_a;
    logic           ready_a;
    logic [PW-1:0]  payload_b;
    logic [IDW-1:0] id_b;
    logic [QW-1:0]  qos_b;
    logic           valid_b;
    logic           ready_b;
    logic           valid_c;
    logic [PW-1:0]  payload_c;
    logic [IDW:0]   id_c;
    logic [QW-1:0]  qos_c;
    logic           ready_c;
    logic           conflict_c;
    logic           release_c;
    logic [IDW:0]   releaseid_c;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    beat_t mon_beat;

    enigma_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .payload_a   (payload_a),
        .id_a        (id_a),
        .qos_a       (qos_a),
        .valid_a     (valid_a),
        .ready_a     (ready_a),
        .payload_b   (payload_b),
        .id_b        (id_b),
        .qos_b       (qos_b),
        .valid_b     (valid_b),
        .ready_b     (ready_b),
        .valid_c     (valid_c),
        .payload_c   (payload_c),
        .id_c        (id_c),
        .qos_c       (qos_c),
        .ready_c     (ready_c),
        .conflict_c  (conflict_c),
        .release_c   (release_c),
        .releaseid_c (releaseid_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every beat the DUT hands downstream must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && valid_c && ready_c && !conflict_c) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_beat: got id_c=%h with no beat expected", id_c);
            end else begin
                mon_beat = exp_q.pop_front();
                if (payload_c !== mon_beat.p || id_c !== mon_beat.id || qos_c !== mon_beat.q) begin
                    errors++;
                    $display("[TB] FAIL beat_compare: got id=%h qos=%h payload=%h expected id=%h qos=%h payload=%h",
                             id_c, qos_c, payload_c, mon_beat.id, mon_beat.q, mon_beat.p);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_a    = 1'b0;
        valid_b    = 1'b0;
        release_c  = 1'b0;
        conflict_c = 1'b0;
        ready_c    = 1'b1;
    endtask

    task automatic drain(input int n);
        idle();
        repeat (n) step();
    endtask

    task automatic push_beat(input logic [PW-1:0] p, input logic [IDW:0] id, input logic [QW-1:0] q);
        beat_t e;
        e.p = p;
        e.id = id;
        e.q = q;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        payload_a = '0; payload_b = '0; id_a = '0; id_b = '0; qos_a = '0; qos_b = '0;
        releaseid_c = '0;
        rst_n   = 1'b0;
        valid_a = 1'b1;
        valid_b = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_a: got %b expected 0", ready_a); end
        checks++;
        if (ready_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_b: got %b expected 0", ready_b); end
        step();
        checks++;
        if (valid_c !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_c: got %b expected 0", valid_c); end
        checks++;
        if (payload_c !== '0) begin errors++; $display("[TB] FAIL reset_payload_c: got %h expected 0", payload_c); end
        checks++;
        if (id_c !== '0) begin errors++; $display("[TB] FAIL reset_id_c: got %h expected 0", id_c); end
        checks++;
        if (qos_c !== '0) begin errors++; $display("[TB] FAIL reset_qos_c: got %h expected 0", qos_c); end
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_priority();
        do_reset();
        payload_a = 128'hAAAA_0001; id_a = 5'd3; qos_a = 2'd1; valid_a = 1'b1;
        payload_b = 128'hBBBB_0002; id_b = 5'd3; qos_b = 2'd2; valid_b = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_b !== 1'b1) begin errors++; $display("[TB] FAIL prio_ready_b: got %b expected 1", ready_b); end
        checks++;
        if (ready_a !== 1'b0) begin errors++; $display("[TB] FAIL prio_ready_a: got %b expected 0", ready_a); end
        push_beat(128'hBBBB_0002, 6'h23, 2'd2);
        step();
        checks++;
        if (id_c !== 6'h23) begin errors++; $display("[TB] FAIL prio_id_b: got %h expected 23", id_c); end
        checks++;
        if (qos_c !== 2'd2) begin errors++; $display("[TB] FAIL prio_qos_b: got %h expected 2", qos_c); end
        valid_b = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b1) begin errors++; $display("[TB] FAIL prio_ready_a_next: got %b expected 1", ready_a); end
        push_beat(128'hAAAA_0001, 6'h03, 2'd1);
        step();
        valid_a = 1'b0;
        checks++;
        if (id_c !== 6'h03) begin errors++; $display("[TB] FAIL prio_id_a: got %h expected 03", id_c); end
        drain(3);
    endtask

    task automatic test_tie_rr();
        logic exp_a;
        do_reset();
        qos_a = 2'd0; qos_b = 2'd0; valid_a = 1'b1; valid_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            id_a = 5'(i);
            id_b = 5'(i);
            payload_a = {64'hA, 64'(i)};
            payload_b = {64'hB, 64'(i)};
            exp_a = (i % 2 == 0);
            @(negedge clk);
            checks++;
            if (ready_a !== exp_a) begin errors++; $display("[TB] FAIL rr_ready_a[%0d]: got %b expected %b", i, ready_a, exp_a); end
            checks++;
            if (ready_b !== !exp_a) begin errors++; $display("[TB] FAIL rr_ready_b[%0d]: got %b expected %b", i, ready_b, !exp_a); end
            if (exp_a) push_beat(payload_a, {1'b0, 5'(i)}, 2'd0);
            else       push_beat(payload_b, {1'b1, 5'(i)}, 2'd0);
            step();
        end
        drain(3);
    endtask

    task automatic test_id_block();
        do_reset();
        valid_a = 1'b1; id_a = 5'd7; qos_a = 2'd0; payload_a = 128'h7777;
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b1) begin errors++; $display("[TB] FAIL block_first: got %b expected 1", ready_a); end
        push_beat(128'h7777, 6'h07, 2'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ready_a !== 1'b0) begin errors++; $display("[TB] FAIL block_held[%0d]: got %b expected 0", i, ready_a); end
            step();
        end
        release_c = 1'b1;
        releaseid_c = 6'h07;
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b0) begin errors++; $display("[TB] FAIL block_release_cycle: got %b expected 0", ready_a); end
        step();
        release_c = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b1) begin errors++; $display("[TB] FAIL block_after_release: got %b expected 1", ready_a); end
        push_beat(128'h7777, 6'h07, 2'd0);
        step();
        drain(3);
    endtask

    task automatic test_conflict();
        do_reset();
        valid_a = 1'b1; id_a = 5'd1; qos_a = 2'd2; payload_a = 128'hC1C1;
        conflict_c = 1'b1;
        @(negedge clk);
        push_beat(128'hC1C1, 6'h01, 2'd2);
        step();
        valid_a = 1'b0;
        valid_b = 1'b1; id_b = 5'd2; qos_b = 2'd0; payload_b = 128'hC2C2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ready_b !== 1'b0) begin errors++; $display("[TB] FAIL conflict_ready_b[%0d]: got %b expected 0", i, ready_b); end
            checks++;
            if (payload_c !== 128'hC1C1) begin errors++; $display("[TB] FAIL conflict_payload[%0d]: got %h expected c1c1", i, payload_c); end
            checks++;
            if (id_c !== 6'h01 || valid_c !== 1'b1) begin errors++; $display("[TB] FAIL conflict_id[%0d]: got %h/%b expected 01/1", i, id_c, valid_c); end
            step();
        end
        conflict_c = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_b !== 1'b1) begin errors++; $display("[TB] FAIL conflict_release_accept: got %b expected 1", ready_b); end
        push_beat(128'hC2C2, 6'h22, 2'd0);
        step();
        valid_b = 1'b0;
        checks++;
        if (id_c !== 6'h22) begin errors++; $display("[TB] FAIL conflict_new_beat: got %h expected 22", id_c); end
        drain(3);
    endtask

    task automatic test_aging();
        logic exp_b;
        do_reset();
        valid_a = 1'b1; qos_a = 2'd3;
        valid_b = 1'b1; qos_b = 2'd0; id_b = 5'd9; payload_b = 128'hB9;
        for (int k = 0; k < 100; k++) begin
            id_a = 5'(k % 32);
            payload_a = {64'hA6, 64'(k)};
            release_c = valid_c;
            releaseid_c = id_c;
`ifdef ENIGMA_ARB_AGING_EN
            exp_b = (k == 15);
`else
            exp_b = 1'b0;
`endif
            @(negedge clk);
            checks++;
            if (ready_b !== exp_b) begin errors++; $display("[TB] FAIL aging_ready_b[%0d]: got %b expected %b", k, ready_b, exp_b); end
            if (exp_b) push_beat(128'hB9, {1'b1, 5'd9}, 2'd0);
            else       push_beat(payload_a, {1'b0, id_a}, 2'd3);
            step();
            if (exp_b) break;
        end
        drain(3);
    endtask

    task automatic test_reset_midflight();
        do_reset();
        valid_a = 1'b1; id_a = 5'd4; qos_a = 2'd1; payload_a = 128'hD4;
        @(negedge clk);
        push_beat(128'hD4, 6'h04, 2'd1);
        step();
        ready_c = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b0) begin errors++; $display("[TB] FAIL midflight_blocked: got %b expected 0", ready_a); end
        step();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b0) begin errors++; $display("[TB] FAIL midflight_reset_cycle: got %b expected 0", ready_a); end
        exp_q.delete();
        step();
        rst_n = 1'b1;
        checks++;
        if (valid_c !== 1'b0) begin errors++; $display("[TB] FAIL midflight_valid_c: got %b expected 0", valid_c); end
        ready_c = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b1) begin errors++; $display("[TB] FAIL midflight_reaccept: got %b expected 1", ready_a); end
        push_beat(128'hD4, 6'h04, 2'd1);
        step();
        valid_a = 1'b0;
        checks++;
        if (id_c !== 6'h04) begin errors++; $display("[TB] FAIL midflight_id: got %h expected 04", id_c); end
        drain(3);
    endtask

    initial begin
        test_reset();
        test_priority();
        test_tie_rr();
        test_id_block();
        test_conflict();
        test_aging();
        test_reset_midflight();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL queue_drain: got %0d beats left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
